// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers; latency is modelled by a busy counter.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MADD_EN.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Decode of ops that occupy the unit for multiple cycles.
  logic long_op, mult_class;
  always_comb begin
    long_op    = 1'b0;
    mult_class = 1'b0;
    case (mdop)
      OP_MULT, OP_MULTU: begin
        long_op    = 1'b1;
        mult_class = 1'b1;
      end
      OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        long_op    = 1'b1;
        mult_class = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign md_stall = busy_q | (start & long_op);

  // Datapath operates on the latched operands only.
  logic [63:0] sa, sb, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, quo_m, rem_m, quo_s, rem_s, quo_u, rem_u;
  always_comb begin
    sa     = {{32{a_q[31]}}, a_q};
    sb     = {{32{b_q[31]}}, b_q};
    prod_s = sa * sb;
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow corner.
    a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag  = b_q[31] ? (32'd0 - b_q) : b_q;
    quo_m  = a_mag / b_mag;
    rem_m  = a_mag % b_mag;
    quo_s  = (a_q[31] ^ b_q[31]) ? (32'd0 - quo_m) : quo_m;
    rem_s  = a_q[31] ? (32'd0 - rem_m) : rem_m;
    quo_u  = a_q / b_q;
    rem_u  = a_q % b_q;
  end

  logic [63:0] result;
  logic        result_wr;
`ifdef MDU_MADD_EN
  logic [63:0] hilo;
  assign hilo = {hi_q, lo_q};
`endif
  always_comb begin
    result    = {hi_q, lo_q};
    result_wr = 1'b1;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        result    = {rem_s, quo_s};
        result_wr = (b_q != 32'd0);
      end
      OP_DIVU: begin
        result    = {rem_u, quo_u};
        result_wr = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = hilo + prod_s;
      OP_MADDU: result = hilo + prod_u;
      OP_MSUB:  result = hilo - prod_s;
      OP_MSUBU: result = hilo - prod_u;
`endif
      default:  result_wr = 1'b0;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q <= CNT_ONE) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (result_wr) begin
          hi_d = result[63:32];
          lo_d = result[31:0];
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (start) begin
      if (long_op) begin
        a_d    = a;
        b_d    = b;
        op_d   = mdop;
        busy_d = 1'b1;
        cnt_d  = mult_class ? MULT_LOAD : DIV_LOAD;
      end else if (mdop == OP_MTHI) begin
        hi_d = a;
      end else if (mdop == OP_MTLO) begin
        lo_d = a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
